// File: rtl/snake_key_pkg.sv
// Shared constants for the snake key peripheral: register offsets,
// register bit positions and key index names.
package snake_key_pkg;

  // Word offsets decoded from HADDR[3:2]
  typedef enum logic [1:0] {
    REG_DATA   = 2'd0,
    REG_STATUS = 2'd1,
    REG_CTRL   = 2'd2,
    REG_RSVD   = 2'd3
  } reg_addr_e;

  // DATA register
  localparam int DATA_VALID    = 8;

  // STATUS register
  localparam int STAT_KEYS_LSB = 12;
  localparam int STAT_OVF      = 10;
  localparam int STAT_FULL     = 9;
  localparam int STAT_EMPTY    = 8;

  // CTRL register
  localparam int CTRL_IRQ_EN   = 0;
  localparam int CTRL_FLUSH    = 1;
  localparam int CTRL_CLR_OVF  = 2;

  // Key indices within key_in and the event mask
  localparam int KEY_UP        = 0;
  localparam int KEY_DOWN      = 1;
  localparam int KEY_LEFT      = 2;
  localparam int KEY_RIGHT     = 3;

endpackage

// File: rtl/key_debounce.sv
// One key: 2-flop synchroniser, stability counter, debounced level and a
// single-cycle pulse on each accepted 0->1 transition.
module key_debounce #(
  parameter int DEBOUNCE_CYCLES = 500000,
  parameter int CNT_W           = 20
) (
  input  logic clk,
  input  logic rst,
  input  logic key_raw,
  output logic stable,
  output logic rise
);

  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DEBOUNCE_CYCLES - 1);

  logic             sync1;
  logic             sync2;
  logic [CNT_W-1:0] cnt;

  // Bring the asynchronous button into the clock domain
  // NOTE: state registers use non-blocking assignments so every flop samples
  // the pre-edge values, independent of statement order.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync1 <= 1'b0;
      sync2 <= 1'b0;
    end else begin
      sync1 <= key_raw;
      sync2 <= sync1;
    end
  end

  // Accept a new level only after it has differed from stable for the full window
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt    <= '0;
      stable <= 1'b0;
      rise   <= 1'b0;
    end else begin
      rise <= 1'b0;
      if (sync2 != stable) begin
        if (cnt == CNT_MAX) begin
          stable <= sync2;
          cnt    <= '0;
          rise   <= sync2;
        end else begin
          cnt <= cnt + 1'b1;
        end
      end else begin
        cnt <= '0;
      end
    end
  end

endmodule

// File: rtl/snake_key_ahb.sv
// AHB-Lite slave turning four debounced snake-direction buttons into press
// events, queued in a small FIFO with a level interrupt while non-empty.
module snake_key_ahb
  import snake_key_pkg::*;
#(
  parameter int N_KEYS          = 4,
  parameter int DEBOUNCE_CYCLES = 500000,
  parameter int CNT_W           = 20,
  parameter int FIFO_DEPTH      = 8
) (
  input  logic              clk,
  input  logic              RST,
  input  logic [N_KEYS-1:0] key_in,
  input  logic              HSEL,
  input  logic [3:0]        HADDR,
  input  logic [1:0]        HTRANS,
  input  logic              HWRITE,
  input  logic              HREADY,
  input  logic [31:0]       HWDATA,
  output logic [31:0]       HRDATA,
  output logic              HREADYOUT,
  output logic              HRESP,
  output logic              IRQ
);

  localparam int PTR_W = $clog2(FIFO_DEPTH);
  localparam int CNT_FW = PTR_W + 1;
  localparam logic [CNT_FW-1:0] FULL_CNT = CNT_FW'(FIFO_DEPTH);

  logic [N_KEYS-1:0] stable;
  logic [N_KEYS-1:0] rise;
  logic [N_KEYS-1:0] ev_mask;

  logic              dp_valid;
  logic              dp_write;
  reg_addr_e         dp_addr;

  logic [N_KEYS-1:0] mem [FIFO_DEPTH];
  logic [PTR_W-1:0]  wr_ptr;
  logic [PTR_W-1:0]  rd_ptr;
  logic [CNT_FW-1:0] count;
  logic              overflow;
  logic              irq_en;

  logic              rd_phase;
  logic              wr_ctrl;
  logic              flush;
  logic              full;
  logic              push;
  logic              pop;
  logic              do_push;
  logic              unused_bits;

  assign HREADYOUT   = 1'b1;
  assign HRESP       = 1'b0;
  assign unused_bits = ^{HADDR[1:0], HTRANS[0], HWDATA[31:3]};

  for (genvar i = 0; i < N_KEYS; i++) begin : g_key
    key_debounce #(
      .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
      .CNT_W           (CNT_W)
    ) u_deb (
      .clk     (clk),
      .rst     (RST),
      .key_raw (key_in[i]),
      .stable  (stable[i]),
      .rise    (rise[i])
    );
  end

  // Collect all rises of one cycle into a single event for the next cycle
  always_ff @(posedge clk or posedge RST) begin
    if (RST) ev_mask <= '0;
    else     ev_mask <= rise;
  end

  // AHB address phase capture
  always_ff @(posedge clk or posedge RST) begin
    if (RST) begin
      dp_valid <= 1'b0;
      dp_write <= 1'b0;
      dp_addr  <= REG_DATA;
    end else begin
      dp_valid <= HSEL & HTRANS[1] & HREADY;
      dp_write <= HWRITE;
      dp_addr  <= reg_addr_e'(HADDR[3:2]);
    end
  end

  assign rd_phase = dp_valid & ~dp_write;
  assign wr_ctrl  = dp_valid & dp_write & (dp_addr == REG_CTRL);
  assign flush    = wr_ctrl & HWDATA[CTRL_FLUSH];
  assign full     = (count == FULL_CNT);
  assign push     = |ev_mask;
  assign pop      = rd_phase & (dp_addr == REG_DATA) & (count != '0);
  // A pop in the same cycle frees the slot a full FIFO needs
  assign do_push  = push & (~full | pop);

  // Event FIFO storage, pointers and occupancy
  // NOTE: the storage array is reset along with the pointers so that every
  // flop in the block comes out of reset in a known state.
  always_ff @(posedge clk or posedge RST) begin
    if (RST) begin
      for (int i = 0; i < FIFO_DEPTH; i++) mem[i] <= '0;
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else if (flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) begin
        mem[wr_ptr] <= ev_mask;
        wr_ptr      <= wr_ptr + 1'b1;
      end
      if (pop) rd_ptr <= rd_ptr + 1'b1;
      case ({do_push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  // Control bits and sticky overflow; a drop in the clearing cycle still sets it
  always_ff @(posedge clk or posedge RST) begin
    if (RST) begin
      irq_en   <= 1'b0;
      overflow <= 1'b0;
    end else begin
      if (wr_ctrl) begin
        irq_en <= HWDATA[CTRL_IRQ_EN];
        if (HWDATA[CTRL_CLR_OVF]) overflow <= 1'b0;
      end
      if (push & full & ~pop & ~flush) overflow <= 1'b1;
    end
  end

  // Read mux from the registered address and current state
  // NOTE: HRDATA gets a default first so no path through the block leaves it
  // unassigned, which would otherwise infer a latch.
  always_comb begin
    HRDATA = '0;
    if (rd_phase) begin
      case (dp_addr)
        REG_DATA: begin
          if (count != '0) begin
            HRDATA[DATA_VALID] = 1'b1;
            HRDATA[3:0]        = mem[rd_ptr];
          end
        end
        REG_STATUS: begin
          HRDATA[STAT_KEYS_LSB+KEY_UP]    = stable[KEY_UP];
          HRDATA[STAT_KEYS_LSB+KEY_DOWN]  = stable[KEY_DOWN];
          HRDATA[STAT_KEYS_LSB+KEY_LEFT]  = stable[KEY_LEFT];
          HRDATA[STAT_KEYS_LSB+KEY_RIGHT] = stable[KEY_RIGHT];
          HRDATA[STAT_OVF]                = overflow;
          HRDATA[STAT_FULL]               = full;
          HRDATA[STAT_EMPTY]              = (count == '0);
          HRDATA[3:0]                     = 4'(count);
        end
        REG_CTRL: HRDATA[CTRL_IRQ_EN] = irq_en;
        default:  HRDATA = '0;
      endcase
    end
  end

  assign IRQ = irq_en & (count != '0);

endmodule

// File: doc/snake_key_ahb.md
Name: snake_key_ahb

Overview:
- AHB-Lite slave peripheral inside CortexM0_SoC. Turns the four snake-direction push-buttons (up/down/left/right) into debounced press events.
- Events are buffered in a small FIFO for the Cortex-M0 game loop, with a level interrupt while events are pending.
- Sits between the board key pins and the SoC AHB interconnect / NVIC IRQ line.

Parameters:
- N_KEYS, 4, number of key inputs (fixed 4 for register map).
- DEBOUNCE_CYCLES, 500000, stable cycles required before a level change is accepted (10 ms at 50 MHz).
- CNT_W, 20, debounce counter width; must satisfy 2^CNT_W > DEBOUNCE_CYCLES.
- FIFO_DEPTH, 8, event FIFO depth; power of 2, at most 8.

Ports:
- clk  in  1  system clock.
- RST  in  1  reset.
- key_in  in  N_KEYS  raw asynchronous buttons, active-high when pressed.
- HSEL  in  1  slave select.
- HADDR  in  4  byte address; only [3:2] decoded.
- HTRANS  in  2  transfer type.
- HWRITE  in  1  write strobe.
- HREADY  in  1  bus ready.
- HWDATA  in  32  write data.
- HRDATA  out  32  read data.
- HREADYOUT  out  1  slave ready.
- HRESP  out  1  response.
- IRQ  out  1  event-pending interrupt.

Behaviour:
- Clocking/reset: one clock; reset is asynchronous and active-high. Every flop clears on RST=1.
- Outputs during and after reset: HRDATA=0, IRQ=0, HREADYOUT=1, HRESP=0.
- HREADYOUT is tied 1 and HRESP tied 0. Zero wait states, never an error.
- Synchroniser: 2-flop synchroniser per key.
- Debounce, per key:
  - If sync != stable, the counter increments.
  - When the counter reaches DEBOUNCE_CYCLES-1, stable takes the sync value and the counter clears.
  - If sync == stable, the counter clears.
  - Any bounce shorter than DEBOUNCE_CYCLES is therefore rejected.
- Press event:
  - A stable 0->1 edge on any key in a cycle forms mask[3:0] (several keys may share one event).
  - The mask is pushed as one FIFO entry the following cycle.
  - Releases generate no event.
- AHB address phase:
  - Accept when HSEL & HTRANS[1] & HREADY.
  - Register valid, write flag and HADDR[3:2].
- AHB data phase:
  - Writes use HWDATA.
  - HRDATA is combinational from the registered address and current state.
- Register map:
  - 0x0 DATA (RO). Returns {23'b0, valid, 4'b0, mask}.
    - A DATA read with FIFO non-empty pops one entry at the end of the data-phase cycle.
    - If empty, returns 0 and does not pop.
  - 0x4 STATUS (RO). Returns [15:12] current stable key levels, [10] overflow (sticky), [9] full, [8] empty, [3:0] count 0..FIFO_DEPTH.
  - 0x8 CTRL (RW).
    - [0] irq_en (reads back).
    - [1] flush: write-1, self-clearing, reads 0.
    - [2] clear overflow: write-1, reads 0.
  - 0xC: reads 0, writes ignored.
- FIFO boundaries:
  - Push when full: event dropped, overflow set. Exception: a pop in the same cycle makes room, so both occur and count stays FIFO_DEPTH.
  - Push and pop-attempt while empty: read returns 0, push is stored, count becomes 1.
  - Flush concurrently with a push: flush wins, count=0, event dropped.
  - Flush does not clear overflow.
  - Pointers wrap modulo FIFO_DEPTH.
- IRQ = irq_en & (count != 0). Level output, combinational from registers.
- Reset mid-debounce:
  - Counters and stable levels clear.
  - A key held through reset produces one event DEBOUNCE_CYCLES+~3 cycles after release of RST.

Decomposition:
- Package snake_key_pkg:
  - Register offsets (DATA=2'd0, STATUS=2'd1, CTRL=2'd2).
  - STATUS/CTRL bit positions.
  - Key index constants (UP=0, DOWN=1, LEFT=2, RIGHT=3).
- Sub-module key_debounce: synchroniser, counter, stable level and rise pulse for one key, instantiated N_KEYS times.
- FIFO and bus logic stay in the top module.

Test Plan (DEBOUNCE_CYCLES=16, 50 MHz clk):
- Reset: assert RST mid-traffic.
  - Required: IRQ=0; STATUS reads 0x100; CTRL reads 0.
- Clean press: hold key_in[2] for 40 cycles.
  - Required: STATUS count=1.
  - DATA read returns 0x104; the next DATA read returns 0.
- Bounce rejection: toggle key_in[0] with 10-cycle pulses, then release.
  - Required: count stays 0.
  - Follow with a held press; exactly one 0x101 event is produced.
- Overflow: irq_en=1, then 9 separate presses of key 3.
  - Required: IRQ=1 after the first press.
  - STATUS shows count=8, full, overflow (0x608).
  - Write CTRL=0x5; overflow clears, irq_en stays set.
- Full with simultaneous pop and push: time a DATA read into the same cycle as the 9th event push.
  - Required: read returns the oldest entry, count stays 8, overflow stays 0.
- Flush/reset mid-operation: 3 events queued, write CTRL=0x2.
  - Required: count=0, IRQ=0.
  - Assert RST while a key is held mid-debounce; one event appears after release of RST.
